map_arbiter: RTL and testbench

MAP_ARBITER -- requirements
Module: map_arbiter

---
 rtl/map_arbiter.sv | 125 ++++++++++++
 tb/tb_map_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/map_arbiter.sv
// Shares one combinational map ROM between a video row fetcher and NCLI point clients.
// Optional starvation guard: define MAP_ARBITER_STARVE_GUARD_EN.
module map_arbiter #(
   parameter int NCLI       = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vid_req,
   input  logic [4:0]        vid_row,
   output logic              vid_ack,
   output logic [31:0]       vid_bits,
   input  logic [NCLI-1:0]   cli_req,
   input  logic [5*NCLI-1:0] cli_row,
   input  logic [5*NCLI-1:0] cli_col,
   output logic [NCLI-1:0]   cli_ack,
   output logic [NCLI-1:0]   cli_wall,
   output logic [4:0]        map_row,
   input  logic [31:0]       map_bits
);
   localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;

   logic [IW-1:0]   rr_ptr;
   logic            vld_p1;
   logic            vid_p1;
   logic [IW-1:0]   idx_p1;
   logic [4:0]      col_p1;
   logic            vid_pend;
   logic [NCLI-1:0] cli_pend;
   logic            cli_hit;
   logic [IW-1:0]   cli_sel;
   logic            force_cli;
   logic            gnt_vid;
   logic            gnt_cli;
   logic [NCLI-1:0] cli_ack_nxt;

   function automatic logic wall_bit(input logic [31:0] bits, input logic [4:0] col);
      return bits[5'd31 - col];
   endfunction

   function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
      return IW'((int'(idx) + 1) % NCLI);
   endfunction

   // Arbitration: anything with a transaction in stage 1 or in its ack cycle is masked.
   always_comb begin
      vid_pend = vid_req & ~((vld_p1 & vid_p1) | vid_ack);
      for (int i = 0; i < NCLI; i++)
         cli_pend[i] = cli_req[i] & ~((vld_p1 & ~vid_p1 & (idx_p1 == IW'(i))) | cli_ack[i]);
      cli_hit = 1'b0;
      cli_sel = '0;
      for (int k = 0; k < NCLI; k++) begin
         if (!cli_hit && cli_pend[(int'(rr_ptr) + k) % NCLI]) begin
            cli_hit = 1'b1;
            cli_sel = IW'((int'(rr_ptr) + k) % NCLI);
         end
      end
      gnt_vid = vid_pend & ~(force_cli & cli_hit);
      gnt_cli = cli_hit & ~gnt_vid;
   end

   always_comb begin
      cli_ack_nxt = '0;
      if (vld_p1 && !vid_p1)
         cli_ack_nxt[idx_p1] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p1   <= 1'b0;
         map_row  <= '0;
         rr_ptr   <= '0;
         vid_ack  <= 1'b0;
         cli_ack  <= '0;
         vid_bits <= '0;
         cli_wall <= '0;
      end else begin
         // stage 1: grant -> registered ROM address
         vld_p1 <= gnt_vid | gnt_cli;
         if (gnt_vid)
            map_row <= vid_row;
         else if (gnt_cli)
            map_row <= cli_row[5*cli_sel +: 5];
         if (gnt_cli)
            rr_ptr <= rr_next(cli_sel);
         // stage 2: ROM data -> ack strobe and held result
         vid_ack <= vld_p1 & vid_p1;
         cli_ack <= cli_ack_nxt;
         if (vld_p1 && vid_p1)
            vid_bits <= map_bits;
         if (vld_p1 && !vid_p1)
            cli_wall[idx_p1] <= wall_bit(map_bits, col_p1);
      end
   end

   // Tag travels with vld_p1; only meaningful while vld_p1 is set.
   always_ff @(posedge clk) begin
      if (gnt_vid | gnt_cli) begin
         vid_p1 <= gnt_vid;
         idx_p1 <= cli_sel;
         col_p1 <= cli_col[5*cli_sel +: 5];
      end
   end

`ifdef MAP_ARBITER_STARVE_GUARD_EN
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   logic [SW-1:0] starve_cnt;

   assign force_cli = (starve_cnt == SW'(STARVE_MAX));

   always_ff @(posedge clk) begin
      if (!reset)
         starve_cnt <= '0;
      else if (gnt_cli || !cli_hit)
         starve_cnt <= '0;
      else if (gnt_vid)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   // Without the guard video has strict priority; this term is constant 0.
   assign force_cli = (STARVE_MAX < 0);
`endif

endmodule

// File: tb/tb_map_arbiter.sv
// Bench for map_arbiter: directed scenarios then random traffic against a cycle-level model.
module tb_map_arbiter;
   localparam int NCLI       = 4;
   localparam int STARVE_MAX = 3;
   localparam int MAXC       = 4096;
`ifdef MAP_ARBITER_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              vid_req;
   logic [4:0]        vid_row;
   logic              vid_ack;
   logic [31:0]       vid_bits;
   logic [NCLI-1:0]   cli_req;
   logic [5*NCLI-1:0] cli_row;
   logic [5*NCLI-1:0] cli_col;
   logic [NCLI-1:0]   cli_ack;
   logic [NCLI-1:0]   cli_wall;
   logic [4:0]        map_row;
   logic [31:0]       map_bits;

   logic [31:0] rom [32];
   assign map_bits = rom[map_row];

   always #5 clk = ~clk;

   map_arbiter #(.NCLI(NCLI), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_row(vid_row), .vid_ack(vid_ack), .vid_bits(vid_bits),
      .cli_req(cli_req), .cli_row(cli_row), .cli_col(cli_col),
      .cli_ack(cli_ack), .cli_wall(cli_wall),
      .map_row(map_row), .map_bits(map_bits)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference state: busy windows end at the ack cycle; expected acks are scheduled by cycle.
   int              vbusy, vdone, rr, starve;
   int              cbusy [NCLI];
   int              cdone [NCLI];
   logic [31:0]     m_vbits;
   logic [NCLI-1:0] m_wall;
   logic [4:0]      m_row;
   bit              e_vack [MAXC];
   logic [31:0]     e_vdat [MAXC];
   bit [NCLI-1:0]   e_cack [MAXC];
   int              e_widx [MAXC];
   bit              e_wbit [MAXC];
   int              order [5] = '{10, 11, 12, 13, 10};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      bit       rst_edge;
      logic [4:0] grow;
      int       pick;
      int       j;
      rst_edge = !reset;
      grow     = m_row;
      if (rst_edge) begin
         for (int k = 1; k <= 2; k++) begin
            e_vack[cyc+k] = 1'b0;
            e_cack[cyc+k] = '0;
         end
         vbusy = -1;
         for (int i = 0; i < NCLI; i++) cbusy[i] = -1;
         rr = 0;
         starve = 0;
      end else begin
         pick = -1;
         for (int k = 0; k < NCLI; k++) begin
            j = (rr + k) % NCLI;
            if (pick < 0 && cli_req[j] && cyc > cbusy[j]) pick = j;
         end
         if (vid_req && cyc > vbusy && !(GUARD && starve == STARVE_MAX && pick >= 0)) begin
            grow  = vid_row;
            vbusy = cyc + 2;
            vdone = cyc + 2;
            e_vack[cyc+2] = 1'b1;
            e_vdat[cyc+2] = rom[vid_row];
            starve = (pick >= 0) ? starve + 1 : 0;
         end else if (pick >= 0) begin
            grow = cli_row[5*pick +: 5];
            cbusy[pick] = cyc + 2;
            cdone[pick] = cyc + 2;
            e_cack[cyc+2][pick] = 1'b1;
            e_widx[cyc+2] = pick;
            e_wbit[cyc+2] = rom[grow][31 - int'(cli_col[5*pick +: 5])];
            rr = (pick + 1) % NCLI;
            starve = 0;
         end else begin
            starve = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rst_edge) begin
         m_vbits = '0;
         m_wall  = '0;
         m_row   = '0;
      end else begin
         m_row = grow;
         if (e_vack[cyc]) m_vbits = e_vdat[cyc];
         if (e_cack[cyc] != '0) m_wall[e_widx[cyc]] = e_wbit[cyc];
      end
      chk("map_row",  32'(map_row),  32'(m_row));
      chk("vid_ack",  32'(vid_ack),  32'(e_vack[cyc]));
      chk("cli_ack",  32'(cli_ack),  32'(e_cack[cyc]));
      chk("vid_bits", vid_bits,      m_vbits);
      chk("cli_wall", 32'(cli_wall), 32'(m_wall));
   endtask

   task automatic set_cli(input int i, input int r, input int c);
      cli_req[i] = 1'b1;
      cli_row[5*i +: 5] = 5'(r);
      cli_col[5*i +: 5] = 5'(c);
   endtask

   task automatic rand_drive();
      if (!vid_req || vdone < cyc) begin
         vid_req = ($urandom_range(0, 2) != 0);
         vid_row = 5'($urandom);
         vdone   = 1 << 30;
      end
      for (int i = 0; i < NCLI; i++) begin
         if (!cli_req[i] || cdone[i] < cyc) begin
            cli_req[i] = ($urandom_range(0, 1) != 0);
            cli_row[5*i +: 5] = 5'($urandom);
            cli_col[5*i +: 5] = 5'($urandom);
            cdone[i] = 1 << 30;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = $urandom;
      rom[0] = 32'hFFFF_FFFF;
      rom[2] = 32'hC003_000F;
      rom[6] = 32'h8000_0001;
      vbusy = -1; vdone = -1; rr = 0; starve = 0;
      for (int i = 0; i < NCLI; i++) begin cbusy[i] = -1; cdone[i] = -1; end
      m_vbits = '0; m_wall = '0; m_row = '0;
      reset = 1'b0; vid_req = 1'b0; vid_row = '0;
      cli_req = '0; cli_row = '0; cli_col = '0;

      // reset state
      step(); step();
      chk("reset_vid_ack", 32'(vid_ack), 32'd0);
      chk("reset_map_row", 32'(map_row), 32'd0);
      reset = 1'b1;

      // client 0, row 2, col 1 -> wall
      set_cli(0, 2, 1);
      step(); chk("gnt0_row", 32'(map_row), 32'd2);
      step(); chk("ack0", 32'(cli_ack), 32'b0001); chk("wall0", 32'(cli_wall[0]), 32'd1);
      cli_req[0] = 1'b0;
      step(); chk("ack0_pulse", 32'(cli_ack), 32'd0);

      // client 1 first sees a wall, then row 6 col 5 clears it; video row 0 follows
      set_cli(1, 0, 3);
      step(); step(); chk("wall1_set", 32'(cli_wall[1]), 32'd1);
      cli_req[1] = 1'b0;
      step();
      set_cli(1, 6, 5);
      step();
      vid_req = 1'b1; vid_row = 5'd0;
      step(); chk("ack1", 32'(cli_ack), 32'b0010); chk("wall1", 32'(cli_wall[1]), 32'd0);
      cli_req[1] = 1'b0;
      step(); chk("vack", 32'(vid_ack), 32'd1); chk("vbits", vid_bits, 32'hFFFF_FFFF);
      vid_req = 1'b0;
      step();

      // round robin from rr_ptr 0 with all clients held
      reset = 1'b0; step(); reset = 1'b1;
      for (int i = 0; i < NCLI; i++) set_cli(i, 10 + i, i);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_order", 32'(map_row), 32'(order[k]));
      end
      cli_req = '0;
      repeat (3) step();

      // video held with client 2 pending
      vid_req = 1'b1; vid_row = 5'd3; set_cli(2, 4, 7);
      step(); chk("vid_first", 32'(map_row), 32'd3);
      step(); chk("cli2_vid_masked", 32'(map_row), 32'd4);
      repeat (10) step();
      vid_req = 1'b0; cli_req = '0;
      repeat (3) step();

      // reset in the cycle after a grant discards it
      set_cli(3, 9, 0);
      step();
      reset = 1'b0; cli_req = '0;
      step();
      chk("rst_map_row", 32'(map_row), 32'd0);
      chk("rst_vid_bits", vid_bits, 32'd0);
      chk("rst_cli_wall", 32'(cli_wall), 32'd0);
      reset = 1'b1;
      repeat (3) begin
         step();
         chk("rst_noack", 32'(cli_ack), 32'd0);
      end

      // random traffic
      vid_req = 1'b0; cli_req = '0;
      step();
      for (int t = 0; t < 2000; t++) begin
         rand_drive();
         step();
      end
      vid_req = 1'b0; cli_req = '0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
